// File: rtl/conv_frame_scheduler.sv
// conv_frame_scheduler: sequences one conv frame (fill, 3x3 window issue, OFM write, 2x2 pool); SCHED_PERF_EN adds a stall counter
module conv_frame_scheduler #(
   parameter int IMG_W = 14,
   parameter int K     = 3,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          lb_we,
   output logic [AW-1:0] lb_waddr,
   output logic          w_we,
   output logic [3:0]    w_addr,
   output logic          mac_start,
   output logic [1:0]    win_slot,
   output logic [AW-1:0] win_col,
   input  logic          mac_done,
   output logic          ofm_we,
   output logic [AW-1:0] ofm_addr,
   output logic          pool_valid,
   output logic [AW-1:0] pool_base,
   output logic          frame_done,
   output logic          protocol_err,
   output logic [15:0]   stall_cnt
);
   localparam int OW   = IMG_W - K + 1;
   localparam int PW   = OW / 2;
   localparam int NPIX = IMG_W * IMG_W;
   localparam int NWIN = OW * OW;
   typedef enum logic [2:0] {IDLE, FILL, CONV, POOL, DONE} state_t;
   state_t state, state_nx;
   logic [AW-1:0] acc_cnt, in_row, in_col, orow, ocol, ofm_idx, pr, pc;
   logic [1:0] in_slot, o_slot;
   logic busy, accept, issue, win_ready, last_win, last_pool, row_end;
   always_comb begin
      in_ready   = !rst && (state == IDLE || state == FILL ||
                   (state == CONV && in_row != orow + AW'(K) && acc_cnt != AW'(NPIX)));
      accept     = in_valid && in_ready;
      lb_we      = accept;
      lb_waddr   = AW'(in_slot) * AW'(IMG_W) + in_col;
      w_we       = accept && acc_cnt < AW'(K * K);
      w_addr     = acc_cnt[3:0];
      win_slot   = o_slot;
      win_col    = ocol;
      ofm_we     = mac_done && busy;
      ofm_addr   = ofm_idx;
      pool_valid = state == POOL;
      pool_base  = pr * AW'(2 * OW) + pc * AW'(2);
      frame_done = state == DONE;
      win_ready  = acc_cnt >= (orow + AW'(K - 1)) * AW'(IMG_W) + ocol + AW'(K);
      issue      = state == CONV && !busy && win_ready;
      last_win   = ofm_idx == AW'(NWIN - 1);
      last_pool  = pr == AW'(PW - 1) && pc == AW'(PW - 1);
      row_end    = in_col == AW'(IMG_W - 1);
   end
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = accept ? FILL : IDLE;
         FILL:    state_nx = (accept && acc_cnt == AW'((K - 1) * IMG_W + K - 1)) ? CONV : FILL;
         CONV:    state_nx = (ofm_we && last_win) ? POOL : CONV;
         POOL:    state_nx = last_pool ? DONE : POOL;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   // DONE clears every frame counter so the next frame starts from zero
   always_ff @(posedge clk) begin
      if (rst || state == DONE) begin
         acc_cnt   <= '0;
         in_row    <= '0;
         in_col    <= '0;
         in_slot   <= '0;
         orow      <= '0;
         ocol      <= '0;
         o_slot    <= '0;
         ofm_idx   <= '0;
         pr        <= '0;
         pc        <= '0;
         busy      <= 1'b0;
         mac_start <= 1'b0;
      end else begin
         mac_start <= issue;
         busy      <= issue || (busy && !mac_done);
         if (accept) begin
            acc_cnt <= acc_cnt + AW'(1);
            in_col  <= row_end ? '0 : in_col + AW'(1);
            if (row_end) begin
               in_row  <= in_row + AW'(1);
               in_slot <= (in_slot == 2'(K - 1)) ? '0 : in_slot + 2'd1;
            end
         end
         if (ofm_we) begin
            ofm_idx <= ofm_idx + AW'(1);
            ocol    <= (ocol == AW'(OW - 1)) ? '0 : ocol + AW'(1);
            if (ocol == AW'(OW - 1)) begin
               orow   <= orow + AW'(1);
               o_slot <= (o_slot == 2'(K - 1)) ? '0 : o_slot + 2'd1;
            end
         end
         if (state == POOL) begin
            pc <= (pc == AW'(PW - 1)) ? '0 : pc + AW'(1);
            if (pc == AW'(PW - 1)) pr <= pr + AW'(1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst)                   protocol_err <= 1'b0;
      else if (mac_done && !busy) protocol_err <= 1'b1;
   end
`ifdef SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && accept))                   stall_cnt <= '0;
      else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`else
   assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_conv_frame_scheduler.sv
// tb_conv_frame_scheduler: directed frames with a bench-side model of accept/window/pool sequencing
module tb_conv_frame_scheduler;
   logic clk = 0, rst, in_valid, in_ready, lb_we, w_we, mac_start, mac_done;
   logic ofm_we, pool_valid, frame_done, protocol_err;
   logic [7:0] lb_waddr, win_col, ofm_addr, pool_base;
   logic [3:0] w_addr;
   logic [1:0] win_slot;
   logic [15:0] stall_cnt;
   logic resp_done = 0, inj_done = 0, mac_en = 1, mon_en = 0, exp_perr = 0;
   bit exp_rdy, outst;
   int mac_dly = 1, acc, ms, done, pidx, fd, stalls, n_checks = 0, n_errors = 0;
   assign mac_done = resp_done | inj_done;
   always #5 clk = ~clk;
   conv_frame_scheduler dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .lb_we(lb_we), .lb_waddr(lb_waddr), .w_we(w_we), .w_addr(w_addr),
      .mac_start(mac_start), .win_slot(win_slot), .win_col(win_col),
      .mac_done(mac_done), .ofm_we(ofm_we), .ofm_addr(ofm_addr),
      .pool_valid(pool_valid), .pool_base(pool_base), .frame_done(frame_done),
      .protocol_err(protocol_err), .stall_cnt(stall_cnt)
   );
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask
   task automatic clear_model();
      acc = 0; ms = 0; done = 0; pidx = 0; fd = 0; stalls = 0; outst = 0;
   endtask
   // MAC stand-in: answers each mac_start after mac_dly cycles
   initial forever begin
      @(negedge clk);
      if (mac_start) begin
         repeat (mac_dly) @(posedge clk);
         #2;
         if (mac_en) begin
            resp_done = 1;
            @(posedge clk);
            #1 resp_done = 0;
         end
      end
   end
   always @(negedge clk) if (mon_en) begin
      exp_rdy = (acc < 31) ? 1'b1 : (done < 144 && acc < 196 && acc / 14 != done / 12 + 3);
      if (in_valid) chk("in_ready", in_ready, exp_rdy);
      if (in_valid && !exp_rdy) stalls++;
      chk("lb_we", lb_we, in_valid && exp_rdy);
      if (lb_we) begin
         chk("lb_waddr", lb_waddr, ((acc / 14) % 3) * 14 + acc % 14);
         chk("w_we", w_we, acc < 9);
         if (acc < 9) chk("w_addr", w_addr, acc);
         acc++;
      end
      chk("protocol_err", protocol_err, exp_perr);
      if (mac_start) begin
         chk("one_outstanding", outst, 0);
         chk("win_col", win_col, done % 12);
         chk("win_slot", win_slot, (done / 12) % 3);
         outst = 1; ms++;
      end
      if (mac_done && outst) begin
         chk("ofm_we", ofm_we, 1);
         chk("ofm_addr", ofm_addr, done);
         done++; outst = 0;
      end else if (mac_done) begin
         chk("ofm_we_stray", ofm_we, 0);
         exp_perr = 1;
      end
      if (pool_valid) begin
         chk("pool_base", pool_base, (pidx / 6) * 24 + (pidx % 6) * 2);
         pidx++;
      end
      if (frame_done) fd++;
   end
   task automatic check_idle();
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mac_start", mac_start, 0);
      chk("rst_ofm_we", ofm_we, 0);
      chk("rst_ofm_addr", ofm_addr, 0);
      chk("rst_win", {win_slot, win_col}, 0);
      chk("rst_pool", {pool_valid, pool_base}, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_protocol_err", protocol_err, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_wr", {lb_we, lb_waddr, w_we}, 0);
   endtask
   // called at posedge+1; holds rst for exactly one edge
   task automatic do_reset();
      mon_en = 0; mac_en = 0; rst = 1;
      @(posedge clk);
      #1 rst = 0; in_valid = 0; mac_en = 1; exp_perr = 0;
      clear_model();
      mon_en = 1;
      check_idle();
   endtask
   task automatic run_frame(input int dly, input int abort_at);
      int cyc = 0;
      mac_dly = dly;
      clear_model();
      while (fd == 0 && cyc < 20000) begin
         @(posedge clk);
         #1;
         if (abort_at >= 0 && acc == abort_at) begin
            do_reset();
            return;
         end
         in_valid = acc < 196;
         cyc++;
      end
      in_valid = 0;
      chk("timeout", fd != 0, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("accepted", acc, 196);
      chk("mac_starts", ms, 144);
      chk("ofm_writes", done, 144);
      chk("pool_count", pidx, 36);
      chk("frame_done_count", fd, 1);
      chk("idle_ready", in_ready, 1);
      chk("end_protocol_err", protocol_err, exp_perr);
      if (dly > 1) chk("stalled", stalls > 0, 1);
`ifdef SCHED_PERF_EN
      chk("stall_cnt", stall_cnt, stalls);
`else
      chk("stall_cnt", stall_cnt, 0);
`endif
   endtask
   initial begin
      rst = 1; in_valid = 0;
      clear_model();
      repeat (3) @(posedge clk);
      #1 do_reset();
      run_frame(1, -1);
      run_frame(20, -1);
      run_frame(1, 100);
      run_frame(1, -1);
      @(posedge clk);
      #1 inj_done = 1;
      @(posedge clk);
      #1 inj_done = 0;
      @(negedge clk);
      chk("err_set", protocol_err, 1);
      run_frame(1, -1);
      chk("err_held", protocol_err, 1);
      @(posedge clk);
      #1 do_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
